// File: rtl/forward_tracker.sv
// Tracks register tags through EX and the post-EX stages. Generates operand
// forward selects for the EX instruction and the load-use stall for ID.
module forward_tracker #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int AW      = 5,
    parameter int SW      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [NUM_SRC*AW-1:0] id_src_i,
    input  logic [AW-1:0]         id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic [NUM_SRC*SW-1:0] fwd_sel_o,
    output logic [NUM_SRC*AW-1:0] ex_src_o,
    output logic [15:0]           stall_cnt_o
);

    logic                  exValid;
    logic                  exRegwrite;
    logic                  exMemread;
    logic [AW-1:0]         exRd;
    logic [NUM_SRC*AW-1:0] exSrc;

    // Post-EX stages only need what forwarding consumes: validity, write enable, rd.
    logic [DEPTH:1]        stValid;
    logic [DEPTH:1]        stRegwrite;
    logic [AW-1:0]         stRd [1:DEPTH];

    logic [15:0]           stallCnt;
    logic                  srcHit;

    always_comb begin
        srcHit = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (id_src_i[j*AW +: AW] != '0 && id_src_i[j*AW +: AW] == exRd)
                srcHit = 1'b1;
        end
        stall_o = id_valid_i & exValid & exMemread & exRegwrite & (exRd != '0) & srcHit;
    end

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        fwd_sel_o = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (stValid[k] && stRegwrite[k] && stRd[k] != '0 &&
                    stRd[k] == exSrc[j*AW +: AW])
                    fwd_sel_o[j*SW +: SW] = SW'(k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exValid    <= 1'b0;
            exRegwrite <= 1'b0;
            exMemread  <= 1'b0;
            exRd       <= '0;
            exSrc      <= '0;
            stValid    <= '0;
            stRegwrite <= '0;
            for (int k = 1; k <= DEPTH; k++)
                stRd[k] <= '0;
            stallCnt   <= '0;
        end else begin
            if (flush_i || stall_o) begin
                exValid    <= 1'b0;
                exRegwrite <= 1'b0;
                exMemread  <= 1'b0;
                exRd       <= '0;
                exSrc      <= '0;
            end else begin
                exValid    <= id_valid_i;
                exRegwrite <= id_regwrite_i;
                exMemread  <= id_memread_i;
                exRd       <= id_rd_i;
                exSrc      <= id_src_i;
            end

            stValid[1]    <= exValid;
            stRegwrite[1] <= exRegwrite;
            stRd[1]       <= exRd;
            for (int k = 2; k <= DEPTH; k++) begin
                stValid[k]    <= stValid[k-1];
                stRegwrite[k] <= stRegwrite[k-1];
                stRd[k]       <= stRd[k-1];
            end

            if (stall_o && !flush_i && stallCnt != 16'hFFFF)
                stallCnt <= stallCnt + 16'd1;
        end
    end

    assign ex_src_o    = exSrc;
    assign stall_cnt_o = stallCnt;

endmodule

// File: doc/forward_tracker.md
FORWARD_TRACKER -- requirements
Module: forward_tracker

Interface
REQ-001 Parameter NUM_SRC, default 2, number of source-register read ports per instruction.
REQ-002 Parameter DEPTH, default 2, number of post-EX stages tracked as forwarding sources (stage 1 = MEM, stage DEPTH = oldest).
REQ-003 Parameter AW, default 5, register-address width.
REQ-004 Parameter SW, default $clog2(DEPTH+1), width of each forward-select field.
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-low.
REQ-007 id_valid_i  input  1  the instruction in ID is real, not a bubble.
REQ-008 id_src_i  input  NUM_SRC*AW  ID source addresses; field j is bits [j*AW +: AW].
REQ-009 id_rd_i  input  AW  ID destination address.
REQ-010 id_regwrite_i  input  1  the ID instruction writes the register file.
REQ-011 id_memread_i  input  1  the ID instruction is a load.
REQ-012 flush_i  input  1  kill the instruction entering EX at this edge.
REQ-013 stall_o  output  1  load-use hazard; ID and IF must hold.
REQ-014 fwd_sel_o  output  NUM_SRC*SW  per EX source: 0 = register file, k = forward from stage k.
REQ-015 ex_src_o  output  NUM_SRC*AW  source addresses latched for the EX instruction.
REQ-016 stall_cnt_o  output  16  saturating count of stall cycles.

Function
REQ-017 The block SHALL hold a tag entry {valid, regwrite, memread, rd, src[NUM_SRC]} for EX (stage 0) and {valid, regwrite, memread, rd} for stages 1..DEPTH.
REQ-018 stall_o SHALL be combinational: id_valid_i & ex.valid & ex.memread & ex.regwrite & ex.rd != 0 & (any id_src field j == ex.rd).
REQ-019 At each edge, EX SHALL load a bubble (valid=0, others 0) if flush_i=1, else a bubble if stall_o=1, else the ID fields; flush_i has priority over stall_o.
REQ-020 At each edge, stage k SHALL load stage k-1 for k=1..DEPTH, unconditionally (back end never stalls).
REQ-021 A source field of value 0 SHALL never match; fwd_sel_o field j SHALL be 0 when ex_src j = 0.
REQ-022 Field j of fwd_sel_o SHALL be combinational from the current entries: the smallest k in 1..DEPTH with stage k valid & regwrite & rd != 0 & rd == ex_src j, else 0 (youngest producer wins).
REQ-023 A stage entry with regwrite=0 or valid=0 SHALL never be selected, even on address match.
REQ-024 stall_cnt_o SHALL increment by 1 at each edge where stall_o=1 and flush_i=0, and saturate at 16'hFFFF.
REQ-025 One load-use hazard SHALL yield exactly one stall cycle; after it, the load is in stage 1 and the consumer reads it via fwd_sel=DEPTH-relative stage index.
REQ-026 When DEPTH=1, only the MEM stage is tracked and SW=1.

Reset
REQ-027 While rst_i=0, all entries SHALL be invalid with zero fields, stall_cnt_o = 0, stall_o = 0, fwd_sel_o = 0, ex_src_o = 0.
REQ-028 Reset assertion mid-operation SHALL clear state immediately, without waiting for a clock edge; the first edge after release SHALL capture ID normally.

Verification
REQ-029 Back-to-back RAW: issue add r3 (regwrite) then sub with src0=r3 -> next cycle fwd_sel field0 = 1, stall_o = 0.
REQ-030 Distance-2 and priority: writes r4, then r4 again, then a consumer of r4 -> fwd_sel = 1 (youngest), not 2; with one unrelated instruction between a single writer and the consumer -> fwd_sel = 2.
REQ-031 Load-use: load r5 in EX, ID src1=r5 -> stall_o=1 for one cycle, EX gets a bubble, stall_cnt_o=1; next cycle the consumer is in EX with fwd_sel field1 = 2.
REQ-032 r0 and non-writing producers: producer rd=0 or regwrite=0 matching the consumer source -> fwd_sel = 0, stall_o = 0.
REQ-033 Flush and stall in the same cycle: flush_i=1 with stall_o=1 -> EX gets a bubble, stall_cnt_o unchanged.
REQ-034 Reset mid-stream: drop rst_i with live entries -> outputs 0 asynchronously; saturation check: preload count to 16'hFFFE, two stall cycles -> 16'hFFFF held.
